// File: rtl/vga_frame_reader.sv
// VGA timing generator that streams an IMG_W x IMG_H byte image from memory.
// Optional macro VGA_GRAYSCALE_EN: replicate each byte to R/G/B instead of RGB332.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_wr_en,
    input  logic [7:0]  mem_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int IMG_SH = $clog2(IMG_W);
    localparam bit IMG_POW2 = ((1 << IMG_SH) == IMG_W);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_IMG  = HW'(IMG_W);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_IMG  = VW'(IMG_H);

    // Flag bundle bit order: {first, in_img, visible, vs_raw, hs_raw}
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [4:0]    flg1_q, flg1_d;
    logic [4:0]    flg2_q;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          hs_q, hs_d, vs_q, vs_d;
    logic          blank_n_q, blank_n_d;
    logic          fs_q, fs_d;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic          vis, in_img;

    // Next counter position, address and raw timing flags for the current pixel
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
        vis    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        in_img = (h_cnt_q < H_IMG) && (v_cnt_q < V_IMG);
        addr_d = addr_q;
        if (in_img) begin
            if (IMG_POW2)
                addr_d = (16'(v_cnt_q) << IMG_SH) + 16'(h_cnt_q);
            else
                addr_d = 16'(v_cnt_q) * 16'(IMG_W) + 16'(h_cnt_q);
        end
        flg1_d[0] = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
        flg1_d[1] = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);
        flg1_d[2] = vis;
        flg1_d[3] = in_img;
        flg1_d[4] = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Colour decode of the memory byte that lines up with stage-2 flags
    always_comb begin
`ifdef VGA_GRAYSCALE_EN
        pix_r = mem_data;
        pix_g = mem_data;
        pix_b = mem_data;
`else
        pix_r = {mem_data[7:5], mem_data[7:5], mem_data[7:6]};
        pix_g = {mem_data[4:2], mem_data[4:2], mem_data[4:3]};
        pix_b = {4{mem_data[1:0]}};
`endif
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (flg2_q[2] && flg2_q[3]) begin
            r_d = pix_r;
            g_d = pix_g;
            b_d = pix_b;
        end
        hs_d      = ~flg2_q[0];
        vs_d      = ~flg2_q[1];
        blank_n_d = flg2_q[2];
        fs_d      = flg2_q[4];
    end

    // Counters, address register, flag delay line and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            addr_q    <= '0;
            flg1_q    <= '0;
            flg2_q    <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            addr_q    <= addr_d;
            flg1_q    <= flg1_d;
            flg2_q    <= flg1_q;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            fs_q      <= fs_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wr_en   = 1'b0;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader using a shrunken 56x26 timing.
// Memory model returns addr[7:0] one clock after the address.
module tb_vga_frame_reader;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_wr_en;
    logic [7:0]  mem_data;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, frame_start;
    logic        force_en;

    int errs;
    int checks;
    int k;

`ifdef VGA_GRAYSCALE_EN
    localparam logic [23:0] C_E0 = 24'hE0E0E0;
    localparam logic [23:0] C_35 = 24'h353535;
    localparam logic [23:0] C_6A = 24'h6A6A6A;
`else
    localparam logic [23:0] C_E0 = 24'hFF0000;
    localparam logic [23:0] C_35 = 24'h24B655;
    localparam logic [23:0] C_6A = 24'h6D49AA;
`endif

    vga_frame_reader #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .IMG_W(16), .IMG_H(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en),
        .mem_data(mem_data),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        mem_data <= force_en ? 8'hE0 : mem_addr[7:0];

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic goto(input int t);
        while (k < t) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) step();
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h0) begin
            errs++;
            $display("FAIL rst_rgb: got %h want 000000", {vga_r, vga_g, vga_b});
        end
        checks++;
        if (mem_addr !== 16'h0) begin
            errs++;
            $display("FAIL rst_addr: got %h want 0000", mem_addr);
        end
        checks++;
        if ({vga_hs, vga_vs, vga_blank_n, frame_start} !== 4'b1100) begin
            errs++;
            $display("FAIL rst_ctl: got %b want 1100",
                     {vga_hs, vga_vs, vga_blank_n, frame_start});
        end
        checks++;
        if (mem_wr_en !== 1'b0) begin
            errs++;
            $display("FAIL rst_wr_en: got %b want 0", mem_wr_en);
        end
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic test_start(input string nm);
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (frame_start !== (i == 3)) begin
                errs++;
                $display("FAIL %s_fs edge%0d: got %b want %b",
                         nm, i, frame_start, (i == 3));
            end
            checks++;
            if (vga_blank_n !== (i >= 3)) begin
                errs++;
                $display("FAIL %s_blank edge%0d: got %b want %b",
                         nm, i, vga_blank_n, (i >= 3));
            end
        end
    endtask

    task automatic test_rgb332();
        goto(59);
        force_en = 1'b1;
        step();
        force_en = 1'b0;
        step();
        checks++;
        if ({vga_r, vga_g, vga_b} !== C_E0) begin
            errs++;
            $display("FAIL rgb_e0: got %h want %h", {vga_r, vga_g, vga_b}, C_E0);
        end
    endtask

    task automatic test_pixels();
        goto(174);
        checks++;
        if (mem_addr !== 16'h0035) begin
            errs++;
            $display("FAIL addr_5_3: got %h want 0035", mem_addr);
        end
        goto(176);
        checks++;
        if ({vga_r, vga_g, vga_b, vga_blank_n} !== {C_35, 1'b1}) begin
            errs++;
            $display("FAIL pix_5_3: got %h/%b want %h/1",
                     {vga_r, vga_g, vga_b}, vga_blank_n, C_35);
        end
        goto(189);
        checks++;
        if (mem_addr !== 16'h003F) begin
            errs++;
            $display("FAIL addr_hold: got %h want 003f", mem_addr);
        end
        goto(191);
        checks++;
        if ({vga_r, vga_g, vga_b, vga_blank_n} !== 25'h1) begin
            errs++;
            $display("FAIL border_x: got %h/%b want 000000/1",
                     {vga_r, vga_g, vga_b}, vga_blank_n);
        end
        goto(216);
        checks++;
        if ({vga_r, vga_g, vga_b, vga_blank_n, vga_hs} !== 26'h0) begin
            errs++;
            $display("FAIL hblank: got %h/%b/%b want 000000/0/0",
                     {vga_r, vga_g, vga_b}, vga_blank_n, vga_hs);
        end
        goto(347);
        checks++;
        if (mem_addr !== 16'h006A) begin
            errs++;
            $display("FAIL addr_10_6: got %h want 006a", mem_addr);
        end
        goto(349);
        checks++;
        if ({vga_r, vga_g, vga_b} !== C_6A) begin
            errs++;
            $display("FAIL pix_10_6: got %h want %h", {vga_r, vga_g, vga_b}, C_6A);
        end
        goto(568);
        checks++;
        if ({vga_r, vga_g, vga_b, vga_blank_n} !== 25'h1) begin
            errs++;
            $display("FAIL border_y: got %h/%b want 000000/1",
                     {vga_r, vga_g, vga_b}, vga_blank_n);
        end
        goto(1235);
        checks++;
        if ({vga_vs, vga_blank_n} !== 2'b00) begin
            errs++;
            $display("FAIL vsync_on: got %b want 00", {vga_vs, vga_blank_n});
        end
        goto(1347);
        checks++;
        if (vga_vs !== 1'b1) begin
            errs++;
            $display("FAIL vsync_off: got %b want 1", vga_vs);
        end
    endtask

    task automatic test_frames();
        int hs_line, hs_tot, vs_tot, fs_cnt, fs_bad, we_bad;
        hs_line = 0; hs_tot = 0; vs_tot = 0;
        fs_cnt = 0; fs_bad = 0; we_bad = 0;
        goto(1459);
        checks++;
        if (frame_start !== 1'b1) begin
            errs++;
            $display("FAIL fs_frame1: got %b want 1", frame_start);
        end
        for (int i = 1; i <= 2912; i++) begin
            step();
            if (i <= 1456) begin
                if (vga_hs === 1'b0) hs_tot++;
                if (vga_vs === 1'b0) vs_tot++;
                if (i <= 56 && vga_hs === 1'b0) hs_line++;
            end
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (i % 1456 != 0) fs_bad++;
            end
            if (mem_wr_en !== 1'b0) we_bad++;
        end
        checks++;
        if (hs_line != 8) begin
            errs++;
            $display("FAIL hs_line: got %0d want 8", hs_line);
        end
        checks++;
        if (hs_tot != 208) begin
            errs++;
            $display("FAIL hs_frame: got %0d want 208", hs_tot);
        end
        checks++;
        if (vs_tot != 112) begin
            errs++;
            $display("FAIL vs_frame: got %0d want 112", vs_tot);
        end
        checks++;
        if (fs_cnt != 2 || fs_bad != 0) begin
            errs++;
            $display("FAIL fs_period: got %0d pulses %0d misplaced want 2/0",
                     fs_cnt, fs_bad);
        end
        checks++;
        if (we_bad != 0) begin
            errs++;
            $display("FAIL wr_en_run: got %0d high cycles want 0", we_bad);
        end
    endtask

    task automatic test_mid_reset();
        int bad;
        bad = 0;
        goto(4958);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start}
            !== {24'h0, 4'b1100}) begin
            errs++;
            $display("FAIL midrst_out: got %h %b want 000000 1100",
                     {vga_r, vga_g, vga_b},
                     {vga_hs, vga_vs, vga_blank_n, frame_start});
        end
        checks++;
        if (mem_addr !== 16'h0) begin
            errs++;
            $display("FAIL midrst_addr: got %h want 0000", mem_addr);
        end
        repeat (5) begin
            step();
            if ({vga_r, vga_g, vga_b, vga_blank_n, frame_start, mem_addr}
                !== 42'h0 || {vga_hs, vga_vs} !== 2'b11) bad++;
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL midrst_hold: got %0d bad cycles want 0", bad);
        end
        rst_n = 1'b1;
        k = 0;
        test_start("post");
    endtask

    initial begin
        errs = 0;
        checks = 0;
        k = 0;
        force_en = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_start("start");
        test_rgb332();
        test_pixels();
        test_frames();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
